// File: rtl/hash_msg_streamer.sv
// hash_msg_streamer
//   Producer-side driver for the DES-S-box hash core byte interface. The host
//   fills a local byte buffer, pulses start, and the block streams the bytes
//   to the core in lockstep with its 2-cycle-per-byte FSM, captures the 32-bit
//   digest on the first cycle it is valid, and offers it on a valid/ready port.
//
//   Optional build macro: HASH_STREAMER_PROTOCHK_EN adds a sticky proto_err
//   output that flags core_ready misbehaviour against the expected timing.
//
// Ports
//   clk, rst_n              clock and async active-low reset (shared with core)
//   wr_valid/wr_data/wr_ready  host byte writes into the message buffer
//   start                   pulse: hash the loaded bytes
//   busy                    start accepted, digest not yet taken
//   m_valid/m_byte/m_len    core M_valid / message / counter
//   core_digest, core_ready core digest_out / hash_ready
//   dig_valid/dig_data/dig_ready  captured digest handshake
//   proto_err               (macro only) sticky protocol error flag
//
// state    | meaning
// S_LOAD   | accepting host bytes, waiting for start
// S_STREAM | byte idx on m_byte; ph=0 valid cycle, ph=1 core S1 cycle
// S_WAIT   | two cycles for the core to finish; capture on the second
// S_DONE   | digest offered, waiting for dig_ready
module hash_msg_streamer #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    input  logic        start,
    output logic        busy,
    output logic        m_valid,
    output logic [7:0]  m_byte,
    output logic [63:0] m_len,
    input  logic [31:0] core_digest,
    input  logic        core_ready,
    output logic        dig_valid,
    output logic [31:0] dig_data,
    input  logic        dig_ready
`ifdef HASH_STREAMER_PROTOCHK_EN
    , output logic      proto_err
`endif
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_LOAD, S_STREAM, S_WAIT, S_DONE} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] count, count_nx;
    logic [AW-1:0] idx, idx_nx;
    logic          ph, ph_nx;
    logic          wr_fire;
    logic          capture;
    logic [7:0]    byte_nx;
    logic [7:0]    msg_buf [DEPTH];

    always_comb begin
        state_nx = state;
        count_nx = count;
        idx_nx   = idx;
        ph_nx    = ph;
        capture  = 1'b0;
        wr_fire  = (state == S_LOAD) && wr_valid && wr_ready;
        byte_nx  = 8'h00;

        case (state)
            S_LOAD: begin
                if (wr_fire) count_nx = count + AW'(1);
                if (start) begin
                    state_nx = S_STREAM;
                    idx_nx   = '0;
                    ph_nx    = 1'b0;
                end
            end
            S_STREAM: begin
                if (count == '0) begin
                    state_nx = S_WAIT;
                    ph_nx    = 1'b0;
                end else if (!ph) begin
                    ph_nx = 1'b1;
                end else if (idx == count - AW'(1)) begin
                    state_nx = S_WAIT;
                    ph_nx    = 1'b0;
                end else begin
                    idx_nx = idx + AW'(1);
                    ph_nx  = 1'b0;
                end
            end
            S_WAIT: begin
                if (!ph) begin
                    ph_nx = 1'b1;
                end else begin
                    capture  = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (dig_ready) begin
                    state_nx = S_LOAD;
                    count_nx = '0;
                end
            end
            default: state_nx = S_LOAD;
        endcase

        // Byte 0 may be written on the start edge itself (empty buffer plus
        // same-cycle write), so forward wr_data instead of reading the array.
        if (state_nx == S_STREAM) begin
            if ((state == S_LOAD) && (count == '0))
                byte_nx = wr_fire ? wr_data : 8'h00;
            else
                byte_nx = msg_buf[idx_nx[IW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_LOAD;
            count     <= '0;
            idx       <= '0;
            ph        <= 1'b0;
            wr_ready  <= 1'b1;
            busy      <= 1'b0;
            m_valid   <= 1'b0;
            m_byte    <= 8'h00;
            m_len     <= 64'd0;
            dig_valid <= 1'b0;
            dig_data  <= 32'd0;
        end else begin
            state     <= state_nx;
            count     <= count_nx;
            idx       <= idx_nx;
            ph        <= ph_nx;
            wr_ready  <= (state_nx == S_LOAD) && (count_nx < AW'(DEPTH));
            busy      <= (state_nx != S_LOAD);
            m_valid   <= (state_nx == S_STREAM) && !ph_nx;
            m_byte    <= byte_nx;
            dig_valid <= (state_nx == S_DONE);
            if ((state == S_LOAD) && start) m_len <= 64'(count_nx);
            if (capture) dig_data <= core_digest;
        end
    end

    // Buffer has no reset; count alone defines which bytes are meaningful.
    always_ff @(posedge clk) begin
        if (wr_fire) msg_buf[count[IW-1:0]] <= wr_data;
    end

`ifdef HASH_STREAMER_PROTOCHK_EN
    // idx==1 with ph==0 is cycle t0+2, reachable only when L>=2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            proto_err <= 1'b0;
        else if ((capture && !core_ready) ||
                 ((state == S_STREAM) && (idx == AW'(1)) && !ph && core_ready))
            proto_err <= 1'b1;
    end
`else
    logic unused_core_ready;
    assign unused_core_ready = core_ready;
`endif

endmodule
